// File: rtl/tpu_host_pkg.sv
// Shared constants for the TPU host bridge: address map, register offsets,
// STATUS/CTRL bit positions and the sequencer state encoding.
package tpu_host_pkg;

    localparam logic [1:0] REG_WT  = 2'd0;
    localparam logic [1:0] REG_ACT = 2'd1;
    localparam logic [1:0] REG_RES = 2'd2;
    localparam logic [1:0] REG_CSR = 2'd3;

    localparam logic [5:0] OFS_CTRL   = 6'h00;
    localparam logic [5:0] OFS_STATUS = 6'h01;
    localparam logic [5:0] OFS_CFG    = 6'h02;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_CLEAR = 1;

    localparam int unsigned ST_BUSY     = 0;
    localparam int unsigned ST_DONE     = 1;
    localparam int unsigned ST_ERR_BUSY = 2;
    localparam int unsigned ST_ERR_ADDR = 3;
    localparam int unsigned ST_ERR_TO   = 4;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

endpackage

// File: rtl/tpu_host_bridge_byte_bank.sv
// DEPTH x 8 register bank: one synchronous write port, two asynchronous
// read ports (host side and core side). Cleared by reset.
module byte_bank #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] host_addr,
    output logic [7:0]    host_data,
    input  logic [AW-1:0] core_addr,
    output logic [7:0]    core_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign host_data = mem[host_addr];
    assign core_data = mem[core_addr];

endmodule

// File: rtl/tpu_host_bridge.sv
// Host-side bridge between the SPI slave and the TPU core: address decode,
// operand/result banks, control/status registers, run sequencer and watchdog.
module tpu_host_bridge
    import tpu_host_pkg::*;
#(
    parameter int unsigned BANK_DEPTH  = 64,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    input  logic       host_wvalid,
    input  logic       host_wen,
    input  logic       host_start,
    output logic [7:0] host_rdata,
    output logic       host_busy,
    output logic       host_done,
    output logic       core_start,
    output logic [1:0] core_mode,
    input  logic [5:0] core_wt_addr,
    output logic [7:0] core_wt_data,
    input  logic [5:0] core_act_addr,
    output logic [7:0] core_act_data,
    input  logic       core_res_we,
    input  logic [5:0] core_res_addr,
    input  logic [7:0] core_res_data,
    input  logic       core_done,
    output logic       core_abort
);

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    logic [15:0] wd;
    logic [7:0]  cfg;
    logic        err_busy, err_addr, err_to;
    logic [7:0]  status;

    logic [1:0]  region;
    logic [5:0]  idx;
    logic        wr, running;
    logic        hit_wt, hit_act, hit_ctrl, hit_status, hit_cfg;
    logic        start_req, clear_req, addr_err, busy_err;
    logic        wt_we, act_we, cfg_we;
    logic [7:0]  wt_host, act_host, res_host;

    assign region     = host_addr[7:6];
    assign idx        = host_addr[5:0];
    assign wr         = host_wvalid & host_wen;
    assign running    = (state == S_RUN);

    assign hit_wt     = (region == REG_WT);
    assign hit_act    = (region == REG_ACT);
    assign hit_ctrl   = (region == REG_CSR) && (idx == OFS_CTRL);
    assign hit_status = (region == REG_CSR) && (idx == OFS_STATUS);
    assign hit_cfg    = (region == REG_CSR) && (idx == OFS_CFG);

    // Only WT, ACT, CTRL and CFG accept writes; anything else is an address error.
    assign addr_err   = wr & ~(hit_wt | hit_act | hit_ctrl | hit_cfg);
    assign start_req  = host_start | (wr & hit_ctrl & host_wdata[CTRL_START]);
    assign clear_req  = wr & hit_ctrl & host_wdata[CTRL_CLEAR];
    assign busy_err   = running & (start_req | (wr & (hit_wt | hit_act | hit_cfg)));

    assign wt_we      = wr & hit_wt  & ~running;
    assign act_we     = wr & hit_act & ~running;
    assign cfg_we     = wr & hit_cfg & ~running;

    assign status     = {3'b000, err_to, err_addr, err_busy, host_done, host_busy};
    assign core_mode  = cfg[1:0];

    byte_bank #(.DEPTH(BANK_DEPTH), .AW(6)) u_wt (
        .clk(clk), .rst_n(rst_n), .we(wt_we), .waddr(idx), .wdata(host_wdata),
        .host_addr(idx), .host_data(wt_host),
        .core_addr(core_wt_addr), .core_data(core_wt_data)
    );

    byte_bank #(.DEPTH(BANK_DEPTH), .AW(6)) u_act (
        .clk(clk), .rst_n(rst_n), .we(act_we), .waddr(idx), .wdata(host_wdata),
        .host_addr(idx), .host_data(act_host),
        .core_addr(core_act_addr), .core_data(core_act_data)
    );

    // The result bank is written only by the core; the host reads it on the first port.
    byte_bank #(.DEPTH(BANK_DEPTH), .AW(6)) u_res (
        .clk(clk), .rst_n(rst_n), .we(core_res_we), .waddr(core_res_addr), .wdata(core_res_data),
        .host_addr(idx), .host_data(res_host),
        .core_addr(core_res_addr), .core_data()
    );

    always_comb begin
        host_rdata = '0;
        unique case (region)
            REG_WT:  host_rdata = wt_host;
            REG_ACT: host_rdata = act_host;
            REG_RES: host_rdata = res_host;
            default: begin
                if (hit_status)   host_rdata = status;
                else if (hit_cfg) host_rdata = cfg;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wd         <= '0;
            cfg        <= '0;
            err_busy   <= 1'b0;
            err_addr   <= 1'b0;
            err_to     <= 1'b0;
            host_busy  <= 1'b0;
            host_done  <= 1'b0;
            core_start <= 1'b0;
            core_abort <= 1'b0;
        end else begin
            core_start <= 1'b0;
            core_abort <= 1'b0;
            if (cfg_we) cfg <= host_wdata;
            // Clear first so that any event in the same cycle still sets its flag.
            if (clear_req) begin
                host_done <= 1'b0;
                err_busy  <= 1'b0;
                err_addr  <= 1'b0;
                err_to    <= 1'b0;
            end
            if (addr_err) err_addr <= 1'b1;
            if (busy_err) err_busy <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        state      <= S_RUN;
                        core_start <= 1'b1;
                        host_busy  <= 1'b1;
                        host_done  <= 1'b0;
                        wd         <= '0;
                    end
                end
                S_RUN: begin
                    if (core_done) begin
                        state     <= S_IDLE;
                        host_busy <= 1'b0;
                        host_done <= 1'b1;
                    end else if (wd == WD_LAST) begin
                        state      <= S_IDLE;
                        host_busy  <= 1'b0;
                        core_abort <= 1'b1;
                        err_to     <= 1'b1;
                    end else begin
                        wd <= wd + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_host_bridge.sv
// Directed bench for tpu_host_bridge with a 16-cycle watchdog.
module tb_tpu_host_bridge;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] host_addr = '0, host_wdata = '0;
    logic       host_wvalid = 1'b0, host_wen = 1'b0, host_start = 1'b0;
    logic [7:0] host_rdata;
    logic       host_busy, host_done, core_start, core_abort;
    logic [1:0] core_mode;
    logic [5:0] core_wt_addr = '0, core_act_addr = '0, core_res_addr = '0;
    logic [7:0] core_wt_data, core_act_data, core_res_data = '0;
    logic       core_res_we = 1'b0, core_done = 1'b0;

    int total = 0;
    int bad = 0;
    int starts = 0;
    int n;
    int s0;

    tpu_host_bridge #(.BANK_DEPTH(64), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_wvalid(host_wvalid), .host_wen(host_wen), .host_start(host_start),
        .host_rdata(host_rdata), .host_busy(host_busy), .host_done(host_done),
        .core_start(core_start), .core_mode(core_mode),
        .core_wt_addr(core_wt_addr), .core_wt_data(core_wt_data),
        .core_act_addr(core_act_addr), .core_act_data(core_act_data),
        .core_res_we(core_res_we), .core_res_addr(core_res_addr), .core_res_data(core_res_data),
        .core_done(core_done), .core_abort(core_abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (core_start) starts <= starts + 1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        host_addr = a;
        #1;
        chk(tag, 16'(host_rdata), 16'(exp));
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        host_addr = a; host_wdata = d; host_wvalid = 1'b1; host_wen = 1'b1;
        @(negedge clk);
        host_wvalid = 1'b0; host_wen = 1'b0;
    endtask

    task automatic pulse_start();
        host_start = 1'b1;
        @(negedge clk);
        host_start = 1'b0;
    endtask

    task automatic pulse_done();
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_busy", 16'(host_busy), 16'h0);
        chk("rst_done", 16'(host_done), 16'h0);
        chk("rst_cstart", 16'(core_start), 16'h0);
        chk("rst_abort", 16'(core_abort), 16'h0);
        chk("rst_mode", 16'(core_mode), 16'h0);
        rd("rst_status", 8'hC1, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1. Bank write/read
        wr(8'h03, 8'h5A);
        wr(8'h45, 8'hA5);
        rd("rd_wt3", 8'h03, 8'h5A);
        rd("rd_act5", 8'h45, 8'hA5);
        core_wt_addr = 6'd3; core_act_addr = 6'd5;
        #1;
        chk("core_wt3", 16'(core_wt_data), 16'h5A);
        chk("core_act5", 16'(core_act_data), 16'hA5);
        wr(8'hC2, 8'h03);
        rd("rd_cfg", 8'hC2, 8'h03);
        chk("core_mode", 16'(core_mode), 16'h3);
        rd("rd_ctrl", 8'hC0, 8'h00);

        // 2. Start / done / clear
        pulse_start();
        chk("cstart_hi", 16'(core_start), 16'h1);
        rd("st_run", 8'hC1, 8'h01);
        @(negedge clk);
        chk("cstart_lo", 16'(core_start), 16'h0);
        repeat (8) @(negedge clk);
        pulse_done();
        rd("st_done", 8'hC1, 8'h02);
        wr(8'hC0, 8'h02);
        rd("st_clr", 8'hC1, 8'h00);

        // 3. Start and bank write while running
        s0 = starts;
        pulse_start();
        pulse_start();
        wr(8'h00, 8'h11);
        wr(8'hC2, 8'h01);
        rd("st_errbusy", 8'hC1, 8'h05);
        rd("wt0_kept", 8'h00, 8'h00);
        rd("cfg_kept", 8'hC2, 8'h03);
        chk("one_start", 16'(starts - s0), 16'h1);
        pulse_done();
        rd("st_done_eb", 8'hC1, 8'h06);
        wr(8'hC0, 8'h02);

        // 4. Watchdog expiry after 16 busy cycles
        pulse_start();
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (core_abort) break;
            if (host_busy) n++;
            @(negedge clk);
        end
        chk("abort_seen", 16'(core_abort), 16'h1);
        chk("busy_cycles", 16'(n), 16'd16);
        rd("st_to", 8'hC1, 8'h10);
        @(negedge clk);
        chk("abort_1cyc", 16'(core_abort), 16'h0);
        pulse_start();
        chk("restart", 16'(core_start), 16'h1);
        pulse_done();
        wr(8'hC0, 8'h02);

        // 5. Address errors and result bank
        wr(8'h85, 8'h99);
        rd("st_erraddr", 8'hC1, 8'h08);
        rd("res5_ro", 8'h85, 8'h00);
        wr(8'hF0, 8'h12);
        rd("rd_unmapped", 8'hF0, 8'h00);
        core_res_we = 1'b1; core_res_addr = 6'd5; core_res_data = 8'h77;
        @(negedge clk);
        core_res_data = 8'h88;
        rd("res_old", 8'h85, 8'h77);
        @(negedge clk);
        core_res_we = 1'b0;
        rd("res_new", 8'h85, 8'h88);
        wr(8'hC0, 8'h02);

        // 6a. core_done on the expiry cycle
        pulse_start();
        repeat (15) @(negedge clk);
        pulse_done();
        chk("race_abort", 16'(core_abort), 16'h0);
        rd("race_st", 8'hC1, 8'h02);
        wr(8'hC0, 8'h02);

        // 6b. core_done with start in the same cycle
        pulse_start();
        host_start = 1'b1; core_done = 1'b1;
        @(negedge clk);
        host_start = 1'b0; core_done = 1'b0;
        chk("dn_st_cstart", 16'(core_start), 16'h0);
        rd("dn_st", 8'hC1, 8'h06);

        // 6c. CTRL clear with core_done in the same cycle
        pulse_start();
        core_done = 1'b1;
        wr(8'hC0, 8'h02);
        core_done = 1'b0;
        rd("clr_dn", 8'hC1, 8'h02);

        // 6d. core_done while idle is ignored
        wr(8'hC0, 8'h02);
        pulse_done();
        rd("idle_done", 8'hC1, 8'h00);

        // 6e. Reset mid-run
        pulse_start();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", 16'(host_busy), 16'h0);
        chk("mr_abort", 16'(core_abort), 16'h0);
        chk("mr_mode", 16'(core_mode), 16'h0);
        rd("mr_status", 8'hC1, 8'h00);
        rd("mr_wt3", 8'h03, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("mr_no_abort", 16'(core_abort), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
